// File: rtl/ex_operand_stage.sv
// Issue stage ahead of the ALU: decodes the ALU op, selects and forwards operands, and buffers entries in a 2-deep skid.
// One-cycle latency, full throughput; DEC_READY is registered and drops only when both head and skid are occupied.
module ex_operand_stage #(
    parameter int XLEN     = 32,
    parameter int REGIDX_W = 5
) (
    input  logic                CLK,
    input  logic                RST_n,
    input  logic                FLUSH,
    input  logic                DEC_VALID,
    output logic                DEC_READY,
    input  logic [6:0]          OPCODE,
    input  logic [2:0]          FUNCT3,
    input  logic                FUNCT7_5,
    input  logic [REGIDX_W-1:0] RS1_IDX,
    input  logic [REGIDX_W-1:0] RS2_IDX,
    input  logic [XLEN-1:0]     RS1_DATA,
    input  logic [XLEN-1:0]     RS2_DATA,
    input  logic [XLEN-1:0]     IMM,
    input  logic [XLEN-1:0]     PC,
    input  logic [REGIDX_W-1:0] RD_IDX,
    input  logic                WB_WE,
    input  logic [REGIDX_W-1:0] WB_RD,
    input  logic [XLEN-1:0]     WB_DATA,
    output logic                EX_VALID,
    input  logic                EX_READY,
    output logic [2:0]          ALU_OP,
    output logic                JALR,
    output logic [XLEN-1:0]     OP1,
    output logic [XLEN-1:0]     OP2,
    output logic [REGIDX_W-1:0] RD_OUT,
    output logic                ILLEGAL
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam int ENT_W = 3 + 1 + XLEN + XLEN + REGIDX_W + 1;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state, next_state;

    logic [XLEN-1:0]  src1, src2;
    logic [2:0]       dec_alu_op;
    logic             dec_jalr;
    logic             dec_illegal;
    logic [XLEN-1:0]  dec_op1, dec_op2;
    logic [ENT_W-1:0] dec_ent, head_ent, skid_ent;

    logic accept, consume;
    logic head_from_dec, head_from_skid, skid_we;

    // Forwarding only applies at capture; buffered entries keep what they captured.
    always_comb begin
        src1 = RS1_DATA;
        if (RS1_IDX == '0)
            src1 = '0;
        else if (WB_WE && (WB_RD == RS1_IDX))
            src1 = WB_DATA;

        src2 = RS2_DATA;
        if (RS2_IDX == '0)
            src2 = '0;
        else if (WB_WE && (WB_RD == RS2_IDX))
            src2 = WB_DATA;
    end

    always_comb begin
        dec_alu_op  = 3'b000;
        dec_jalr    = 1'b0;
        dec_illegal = 1'b0;
        dec_op1     = src1;
        dec_op2     = IMM;
        case (OPCODE)
            OPC_OP, OPC_OPIMM: begin
                if (OPCODE == OPC_OP)
                    dec_op2 = src2;
                case (FUNCT3)
                    3'b000:  dec_alu_op = (OPCODE == OPC_OP && FUNCT7_5) ? 3'b010 : 3'b000;
                    3'b001:  dec_alu_op = 3'b001;
                    3'b100:  dec_alu_op = 3'b100;
                    3'b101:  dec_alu_op = FUNCT7_5 ? 3'b101 : 3'b011;
                    3'b111:  dec_alu_op = 3'b111;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_JALR:  dec_jalr = 1'b1;
            OPC_LUI:   dec_op1  = '0;
            OPC_AUIPC: dec_op1  = PC;
            default:   dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_alu_op = 3'b110;
            dec_jalr   = 1'b0;
            dec_op1    = '0;
            dec_op2    = '0;
        end
    end

    assign dec_ent  = {dec_alu_op, dec_jalr, dec_op1, dec_op2, RD_IDX, dec_illegal};
    assign EX_VALID = (state != EMPTY);
    assign accept   = DEC_VALID && DEC_READY;
    assign consume  = EX_VALID && EX_READY;

    always_comb begin
        next_state     = state;
        head_from_dec  = 1'b0;
        head_from_skid = 1'b0;
        skid_we        = 1'b0;
        if (FLUSH) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        next_state    = ONE;
                        head_from_dec = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        head_from_dec = 1'b1;
                    end else if (accept) begin
                        next_state = TWO;
                        skid_we    = 1'b1;
                    end else if (consume) begin
                        next_state = EMPTY;
                    end
                end
                TWO: begin
                    if (consume) begin
                        next_state     = ONE;
                        head_from_skid = 1'b1;
                    end
                end
                default: next_state = EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state     <= EMPTY;
            DEC_READY <= 1'b0;
            head_ent  <= '0;
            skid_ent  <= '0;
        end else begin
            state     <= next_state;
            DEC_READY <= (next_state != TWO);
            if (head_from_dec)
                head_ent <= dec_ent;
            else if (head_from_skid)
                head_ent <= skid_ent;
            if (skid_we)
                skid_ent <= dec_ent;
        end
    end

    assign {ALU_OP, JALR, OP1, OP2, RD_OUT, ILLEGAL} = head_ent;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_ex_operand_stage;

    logic        CLK, RST_n, FLUSH, DEC_VALID, DEC_READY;
    logic [6:0]  OPCODE;
    logic [2:0]  FUNCT3;
    logic        FUNCT7_5;
    logic [4:0]  RS1_IDX, RS2_IDX, RD_IDX, WB_RD, RD_OUT;
    logic [31:0] RS1_DATA, RS2_DATA, IMM, PC, WB_DATA, OP1, OP2;
    logic        WB_WE, EX_VALID, EX_READY, JALR, ILLEGAL;
    logic [2:0]  ALU_OP;

    typedef struct packed {
        logic [2:0]  alu_op;
        logic        jalr;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        illegal;
    } ent_t;

    int pass_cnt = 0;
    int total_cnt = 0;

    ex_operand_stage dut (
        .CLK(CLK), .RST_n(RST_n), .FLUSH(FLUSH),
        .DEC_VALID(DEC_VALID), .DEC_READY(DEC_READY),
        .OPCODE(OPCODE), .FUNCT3(FUNCT3), .FUNCT7_5(FUNCT7_5),
        .RS1_IDX(RS1_IDX), .RS2_IDX(RS2_IDX), .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA),
        .IMM(IMM), .PC(PC), .RD_IDX(RD_IDX),
        .WB_WE(WB_WE), .WB_RD(WB_RD), .WB_DATA(WB_DATA),
        .EX_VALID(EX_VALID), .EX_READY(EX_READY),
        .ALU_OP(ALU_OP), .JALR(JALR), .OP1(OP1), .OP2(OP2),
        .RD_OUT(RD_OUT), .ILLEGAL(ILLEGAL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic ent_t head_now();
        return ent_t'({ALU_OP, JALR, OP1, OP2, RD_OUT, ILLEGAL});
    endfunction

    function automatic ent_t mk(input logic [2:0] a, input logic j, input logic [31:0] o1,
                                input logic [31:0] o2, input logic [4:0] rd, input logic il);
        ent_t e;
        e.alu_op = a; e.jalr = j; e.op1 = o1; e.op2 = o2; e.rd = rd; e.illegal = il;
        return e;
    endfunction

    // Reference: what the instruction currently on the decode inputs should become.
    function automatic ent_t ref_entry();
        logic [31:0] a, b;
        ent_t e;
        a = (RS1_IDX == 0) ? 32'd0 : ((WB_WE && WB_RD == RS1_IDX) ? WB_DATA : RS1_DATA);
        b = (RS2_IDX == 0) ? 32'd0 : ((WB_WE && WB_RD == RS2_IDX) ? WB_DATA : RS2_DATA);
        e = mk(3'd0, 1'b0, 32'd0, 32'd0, RD_IDX, 1'b0);
        if (OPCODE == 7'b0110011 || OPCODE == 7'b0010011) begin
            e.op1 = a;
            e.op2 = (OPCODE == 7'b0110011) ? b : IMM;
            if (FUNCT3 == 3'd0)      e.alu_op = (OPCODE == 7'b0110011 && FUNCT7_5) ? 3'd2 : 3'd0;
            else if (FUNCT3 == 3'd1) e.alu_op = 3'd1;
            else if (FUNCT3 == 3'd4) e.alu_op = 3'd4;
            else if (FUNCT3 == 3'd5) e.alu_op = FUNCT7_5 ? 3'd5 : 3'd3;
            else if (FUNCT3 == 3'd7) e.alu_op = 3'd7;
            else                     e.illegal = 1'b1;
        end else if (OPCODE == 7'b1100111) begin
            e.op1 = a; e.op2 = IMM; e.jalr = 1'b1;
        end else if (OPCODE == 7'b0110111) begin
            e.op2 = IMM;
        end else if (OPCODE == 7'b0010111) begin
            e.op1 = PC; e.op2 = IMM;
        end else begin
            e.illegal = 1'b1;
        end
        if (e.illegal) e = mk(3'd6, 1'b0, 32'd0, 32'd0, RD_IDX, 1'b1);
        return e;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] im, input logic [31:0] pcv,
                         input logic [4:0] rd);
        DEC_VALID = 1'b1; OPCODE = op; FUNCT3 = f3; FUNCT7_5 = f75;
        RS1_IDX = r1; RS2_IDX = r2; RS1_DATA = d1; RS2_DATA = d2;
        IMM = im; PC = pcv; RD_IDX = rd; WB_WE = 1'b0; WB_RD = 5'd0; WB_DATA = 32'd0;
    endtask

    task automatic test_reset();
        RST_n = 1'b1; FLUSH = 1'b0; EX_READY = 1'b0;
        drive(7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        DEC_VALID = 1'b0;
        #2 RST_n = 1'b0;
        #1;
        total_cnt++;
        if ({EX_VALID, DEC_READY, head_now()} !== '0) $display("FAIL reset_outputs: got %b/%b/%h want all zero", EX_VALID, DEC_READY, head_now());
        else pass_cnt++;
        repeat (2) @(posedge CLK);
        #1 RST_n = 1'b1;
        total_cnt++;
        if (DEC_READY !== 1'b0) $display("FAIL reset_ready_before_edge: got %b want 0", DEC_READY);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (DEC_READY !== 1'b1 || EX_VALID !== 1'b0) $display("FAIL reset_ready_after_edge: got rdy=%b vld=%b want 1/0", DEC_READY, EX_VALID);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        EX_READY = 1'b1;
        drive(7'b0110011, 3'd0, 1'b0, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3);
        tick();
        total_cnt++;
        if (EX_VALID !== 1'b1 || head_now() !== mk(3'd0, 1'b0, 32'd5, 32'd7, 5'd3, 1'b0) || DEC_READY !== 1'b1)
            $display("FAIL b2b_add: got vld=%b rdy=%b %h", EX_VALID, DEC_READY, head_now());
        else pass_cnt++;
        FUNCT7_5 = 1'b1;
        tick();
        total_cnt++;
        if (EX_VALID !== 1'b1 || head_now() !== mk(3'd2, 1'b0, 32'd5, 32'd7, 5'd3, 1'b0) || DEC_READY !== 1'b1)
            $display("FAIL b2b_sub: got vld=%b rdy=%b %h", EX_VALID, DEC_READY, head_now());
        else pass_cnt++;
        DEC_VALID = 1'b0;
        tick();
        total_cnt++;
        if (EX_VALID !== 1'b0) $display("FAIL b2b_drain: got vld=%b want 0", EX_VALID);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        ent_t i1, i2, i3;
        i1 = mk(3'd0, 1'b0, 32'h11, 32'd1, 5'd7, 1'b0);
        i2 = mk(3'd4, 1'b0, 32'h22, 32'd2, 5'd8, 1'b0);
        i3 = mk(3'd7, 1'b0, 32'h33, 32'd3, 5'd9, 1'b0);
        EX_READY = 1'b0;
        drive(7'b0010011, 3'd0, 1'b0, 5'd1, 5'd0, 32'h11, 32'd0, 32'd1, 32'd0, 5'd7);
        tick();
        total_cnt++;
        if (EX_VALID !== 1'b1 || DEC_READY !== 1'b1 || head_now() !== i1) $display("FAIL bp_first: got vld=%b rdy=%b %h", EX_VALID, DEC_READY, head_now());
        else pass_cnt++;
        drive(7'b0010011, 3'd4, 1'b0, 5'd2, 5'd0, 32'h22, 32'd0, 32'd2, 32'd0, 5'd8);
        tick();
        total_cnt++;
        if (DEC_READY !== 1'b0 || head_now() !== i1) $display("FAIL bp_full: got rdy=%b %h want rdy=0", DEC_READY, head_now());
        else pass_cnt++;
        drive(7'b0010011, 3'd7, 1'b0, 5'd3, 5'd0, 32'h33, 32'd0, 32'd3, 32'd0, 5'd9);
        repeat (2) begin
            tick();
            total_cnt++;
            if (EX_VALID !== 1'b1 || DEC_READY !== 1'b0 || head_now() !== i1) $display("FAIL bp_hold: got vld=%b rdy=%b %h", EX_VALID, DEC_READY, head_now());
            else pass_cnt++;
        end
        EX_READY = 1'b1;
        tick();
        total_cnt++;
        if (head_now() !== i2 || DEC_READY !== 1'b1) $display("FAIL bp_order2: got rdy=%b %h want %h", DEC_READY, head_now(), i2);
        else pass_cnt++;
        tick();
        DEC_VALID = 1'b0;
        total_cnt++;
        if (EX_VALID !== 1'b1 || head_now() !== i3) $display("FAIL bp_order3: got vld=%b %h want %h", EX_VALID, head_now(), i3);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (EX_VALID !== 1'b0) $display("FAIL bp_drain: got vld=%b want 0", EX_VALID);
        else pass_cnt++;
    endtask

    task automatic test_forwarding();
        EX_READY = 1'b1;
        drive(7'b0010011, 3'd0, 1'b0, 5'd4, 5'd0, 32'd1, 32'd0, 32'hFFFFFFFC, 32'd0, 5'd5);
        WB_WE = 1'b1; WB_RD = 5'd4; WB_DATA = 32'h10;
        tick();
        total_cnt++;
        if (head_now() !== mk(3'd0, 1'b0, 32'h10, 32'hFFFFFFFC, 5'd5, 1'b0)) $display("FAIL fwd_hit: got %h", head_now());
        else pass_cnt++;
        RS1_IDX = 5'd0; WB_RD = 5'd0;
        tick();
        total_cnt++;
        if (head_now() !== mk(3'd0, 1'b0, 32'h0, 32'hFFFFFFFC, 5'd5, 1'b0)) $display("FAIL fwd_x0: got %h", head_now());
        else pass_cnt++;
        DEC_VALID = 1'b0;
        tick();
    endtask

    task automatic test_special();
        EX_READY = 1'b1;
        drive(7'b1100111, 3'd0, 1'b0, 5'd6, 5'd0, 32'h1001, 32'd0, 32'd2, 32'd0, 5'd1);
        tick();
        total_cnt++;
        if (head_now() !== mk(3'd0, 1'b1, 32'h1001, 32'd2, 5'd1, 1'b0)) $display("FAIL sp_jalr: got %h", head_now());
        else pass_cnt++;
        drive(7'b0010111, 3'd0, 1'b0, 5'd6, 5'd0, 32'h55, 32'd0, 32'h1000, 32'h400, 5'd2);
        tick();
        total_cnt++;
        if (head_now() !== mk(3'd0, 1'b0, 32'h400, 32'h1000, 5'd2, 1'b0)) $display("FAIL sp_auipc: got %h", head_now());
        else pass_cnt++;
        drive(7'b0010011, 3'd5, 1'b1, 5'd6, 5'd0, 32'h80, 32'd0, 32'd4, 32'd0, 5'd3);
        tick();
        total_cnt++;
        if (head_now() !== mk(3'd5, 1'b0, 32'h80, 32'd4, 5'd3, 1'b0)) $display("FAIL sp_srai: got %h", head_now());
        else pass_cnt++;
        drive(7'b0000011, 3'd2, 1'b0, 5'd6, 5'd0, 32'h80, 32'd0, 32'd4, 32'd0, 5'd4);
        tick();
        total_cnt++;
        if (head_now() !== mk(3'd6, 1'b0, 32'd0, 32'd0, 5'd4, 1'b1)) $display("FAIL sp_illegal_opc: got %h", head_now());
        else pass_cnt++;
        drive(7'b0110011, 3'd6, 1'b0, 5'd6, 5'd7, 32'h80, 32'h9, 32'd4, 32'd0, 5'd5);
        tick();
        total_cnt++;
        if (head_now() !== mk(3'd6, 1'b0, 32'd0, 32'd0, 5'd5, 1'b1)) $display("FAIL sp_illegal_f3: got %h", head_now());
        else pass_cnt++;
        drive(7'b0110111, 3'd0, 1'b0, 5'd6, 5'd0, 32'h80, 32'd0, 32'hABCD0000, 32'h400, 5'd6);
        tick();
        total_cnt++;
        if (head_now() !== mk(3'd0, 1'b0, 32'd0, 32'hABCD0000, 5'd6, 1'b0)) $display("FAIL sp_lui: got %h", head_now());
        else pass_cnt++;
        DEC_VALID = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        EX_READY = 1'b0;
        drive(7'b0010011, 3'd0, 1'b0, 5'd1, 5'd0, 32'd1, 32'd0, 32'd1, 32'd0, 5'd1);
        tick();
        RD_IDX = 5'd2;
        tick();
        RD_IDX = 5'd3; FLUSH = 1'b1;
        tick();
        total_cnt++;
        if (EX_VALID !== 1'b0 || DEC_READY !== 1'b1) $display("FAIL flush_two: got vld=%b rdy=%b want 0/1", EX_VALID, DEC_READY);
        else pass_cnt++;
        FLUSH = 1'b0; DEC_VALID = 1'b0; EX_READY = 1'b1;
        tick();
        total_cnt++;
        if (EX_VALID !== 1'b0) $display("FAIL flush_two_after: got vld=%b want 0", EX_VALID);
        else pass_cnt++;
        DEC_VALID = 1'b1; RD_IDX = 5'd4; EX_READY = 1'b0;
        tick();
        RD_IDX = 5'd5; FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0; DEC_VALID = 1'b0;
        total_cnt++;
        if (EX_VALID !== 1'b0 || DEC_READY !== 1'b1) $display("FAIL flush_one_accept: got vld=%b rdy=%b want 0/1", EX_VALID, DEC_READY);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (EX_VALID !== 1'b0) $display("FAIL flush_one_after: got vld=%b want 0", EX_VALID);
        else pass_cnt++;
    endtask

    task automatic test_reset_midstream();
        EX_READY = 1'b0;
        drive(7'b0110011, 3'd7, 1'b0, 5'd1, 5'd2, 32'hF0, 32'hFF, 32'd0, 32'd0, 5'd9);
        tick();
        tick();
        DEC_VALID = 1'b0;
        #2 RST_n = 1'b0;
        #1;
        total_cnt++;
        if ({EX_VALID, DEC_READY, head_now()} !== '0) $display("FAIL midreset_outputs: got %b/%b/%h want all zero", EX_VALID, DEC_READY, head_now());
        else pass_cnt++;
        @(negedge CLK);
        #1 RST_n = 1'b1;
        tick();
        total_cnt++;
        if (DEC_READY !== 1'b1 || EX_VALID !== 1'b0) $display("FAIL midreset_release: got rdy=%b vld=%b want 1/0", DEC_READY, EX_VALID);
        else pass_cnt++;
    endtask

    task automatic test_random();
        ent_t q[$];
        ent_t exp;
        logic acc, con;
        FLUSH = 1'b1; DEC_VALID = 1'b0;
        tick();
        FLUSH = 1'b0;
        for (int n = 0; n < 400; n++) begin
            total_cnt++;
            if (EX_VALID !== (q.size() > 0) || DEC_READY !== (q.size() < 2))
                $display("FAIL rnd_flags[%0d]: got vld=%b rdy=%b want occupancy %0d", n, EX_VALID, DEC_READY, q.size());
            else pass_cnt++;
            if (q.size() > 0) begin
                total_cnt++;
                if (head_now() !== q[0]) $display("FAIL rnd_head[%0d]: got %h want %h", n, head_now(), q[0]);
                else pass_cnt++;
            end
            DEC_VALID = ($urandom_range(0, 99) < 70);
            EX_READY  = ($urandom_range(0, 99) < 60);
            FLUSH     = ($urandom_range(0, 99) < 4);
            case ($urandom_range(0, 6))
                0: OPCODE = 7'b0110011;
                1: OPCODE = 7'b0010011;
                2: OPCODE = 7'b1100111;
                3: OPCODE = 7'b0110111;
                4: OPCODE = 7'b0010111;
                5: OPCODE = 7'b0000011;
                default: OPCODE = 7'($urandom);
            endcase
            FUNCT3 = 3'($urandom); FUNCT7_5 = 1'($urandom);
            RS1_IDX = 5'($urandom_range(0, 3)); RS2_IDX = 5'($urandom_range(0, 3));
            RS1_DATA = $urandom; RS2_DATA = $urandom; IMM = $urandom; PC = $urandom;
            RD_IDX = 5'($urandom); WB_WE = 1'($urandom);
            WB_RD = 5'($urandom_range(0, 3)); WB_DATA = $urandom;
            exp = ref_entry();
            acc = DEC_VALID && (q.size() < 2);
            con = (q.size() > 0) && EX_READY;
            if (FLUSH) q.delete();
            else begin
                if (con) void'(q.pop_front());
                if (acc) q.push_back(exp);
            end
            tick();
        end
        FLUSH = 1'b0; DEC_VALID = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_forwarding();
        test_special();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- Issue stage directly upstream of the ALU.
- Accepts one decoded instruction per cycle from decode via valid/ready.
- Selects operands: register data, immediate, PC, or zero, with writeback forwarding.
- Translates opcode/funct into the ALU's 3-bit operation code and JALR flag.
- Presents registered, stable OP1/OP2/ALU_OP/JALR to the combinational ALU through a 2-entry skid buffer, so DEC_READY is a registered signal.

Parameters:
- XLEN, 32, datapath width of operands, PC and immediate.
- REGIDX_W, 5, register index width.

Ports:
- CLK  in  1  single clock, rising edge.
- RST_n  in  1  asynchronous active-low reset.
- FLUSH  in  1  synchronous kill of all buffered entries (branch/jump redirect).
- DEC_VALID  in  1  decode presents an instruction.
- DEC_READY  out  1  stage can accept; registered.
- OPCODE  in  7  RISC-V opcode field.
- FUNCT3  in  3  funct3 field.
- FUNCT7_5  in  1  instruction bit 30.
- RS1_IDX, RS2_IDX  in  REGIDX_W each  source register indices.
- RS1_DATA, RS2_DATA  in  XLEN each  register file read data.
- IMM  in  XLEN  sign-extended immediate from decode.
- PC  in  XLEN  instruction address.
- RD_IDX  in  REGIDX_W  destination index.
- WB_WE  in  1  writeback write enable.
- WB_RD  in  REGIDX_W  writeback destination.
- WB_DATA  in  XLEN  writeback data.
- EX_VALID  out  1  head entry valid toward the ALU.
- EX_READY  in  1  downstream consumes head this cycle.
- ALU_OP  out  3  ALU operation code.
- JALR  out  1  JALR flag (ALU clears result bit 0).
- OP1, OP2  out  XLEN each  ALU operands.
- RD_OUT  out  REGIDX_W  destination passed through.
- ILLEGAL  out  1  head entry carries an unsupported encoding.

Behaviour:
- Reset (RST_n low, asynchronous): all outputs 0, DEC_READY=0; FSM=EMPTY. On the first CLK edge after release, DEC_READY becomes 1.
- Accept event: DEC_VALID && DEC_READY.
- Consume event: EX_VALID && EX_READY.
- FSM states:
  - EMPTY (EX_VALID=0).
  - ONE (head valid, skid empty).
  - TWO (head and skid valid).
- FSM transitions:
  - EMPTY: accept goes to ONE and the new entry is written to head.
  - ONE: accept without consume goes to TWO and the entry is written to skid. Consume without accept goes to EMPTY. Accept with consume stays in ONE and head is replaced.
  - TWO: consume moves skid to head and goes to ONE. Accept is impossible (DEC_READY=0).
- DEC_READY register equals next_state != TWO.
- Latency: an accepted instruction appears on the outputs the next cycle, with zero bubbles at full throughput.
- Head outputs are held stable while EX_VALID && !EX_READY.
- FLUSH has priority over everything: next state EMPTY, EX_VALID=0 next cycle, and any same-cycle accept is discarded. Data registers may retain stale values.
- Forwarding is evaluated at capture only:
  - src = RS1_DATA (or RS2_DATA).
  - If RSx_IDX==0, src=0.
  - Else if WB_WE && WB_RD==RSx_IDX, src=WB_DATA.
  - Entries already buffered are not re-forwarded; hazards beyond that are the upstream hazard unit's responsibility.
- Decode table (ALU_OP / OP1 / OP2 / JALR):
  - OPCODE 0110011 (R-type), OP1=rs1, OP2=rs2:
    - 000 with FUNCT7_5=0 → ADD 000; with FUNCT7_5=1 → SUB 010.
    - 001 → SLL 001.
    - 100 → XOR 100.
    - 101 → SRL 011 (FUNCT7_5=0) or SRA 101 (FUNCT7_5=1).
    - 111 → AND 111.
  - OPCODE 0010011 (I-type), OP1=rs1, OP2=IMM, same mapping:
    - FUNCT7_5 is ignored for 000.
    - 101 uses FUNCT7_5 to pick SRLI/SRAI.
  - 1100111 JALR: ALU_OP=000, OP1=rs1, OP2=IMM, JALR=1.
  - 0110111 LUI: ALU_OP=000, OP1=0, OP2=IMM.
  - 0010111 AUIPC: ALU_OP=000, OP1=PC, OP2=IMM.
  - JALR=0 for every case except the JALR opcode.
- Any other opcode/funct3 combination (including R/I funct3 010, 011, 110):
  - ALU_OP=110, OP1=OP2=0, ILLEGAL=1.
  - The entry still flows through the handshake normally.
- All arithmetic is width-preserving XLEN; there is no sign or zero extension here (IMM arrives pre-extended).

Test Plan:
- Reset mid-stream:
  - Stimulus: entries in TWO; pull RST_n low between edges.
  - Response: EX_VALID, DEC_READY and all data outputs go to 0 immediately. After release, DEC_READY=1 on the next edge.
- Back-to-back, EX_READY=1:
  - Stimulus: ADD x3,x1,x2 (x1=5, x2=7) then SUB.
  - Response: ALU_OP 000 then 010, OP1=5, OP2=7, one per cycle, DEC_READY stays 1.
- Backpressure:
  - Stimulus: EX_READY=0, feed 3 instructions.
  - Response: two accepted, DEC_READY falls after the second. Head is held unchanged. After EX_READY=1, order is preserved.
- Forwarding:
  - Stimulus: ADDI x5,x4,imm=0xFFFFFFFC with RS1_DATA=1, WB_WE=1, WB_RD=4, WB_DATA=0x10.
  - Response: OP1=0x10, OP2=0xFFFFFFFC.
  - Stimulus: repeat with RS1_IDX=0, WB_RD=0.
  - Response: OP1=0.
- Special opcodes:
  - JALR, rs1=0x1001, IMM=2 → JALR=1, ALU_OP=000, OP1=0x1001, OP2=2.
  - AUIPC with PC=0x400 → OP1=0x400.
  - SRAI (FUNCT7_5=1) → ALU_OP=101.
  - OPCODE 0000011 → ILLEGAL=1, ALU_OP=110.
- Flush:
  - Stimulus: in TWO, assert FLUSH together with DEC_VALID.
  - Response: next cycle EX_VALID=0, DEC_READY=1, and the flushed instruction never appears.
